// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO definitions: default widths and the Gray/binary pointer
// conversions used by both the write-side and read-side controllers.
package fifo_pkg;

  localparam int ADDR_W_DEFAULT = 5;
  localparam int PTR_W_DEFAULT  = ADDR_W_DEFAULT + 1;

  // Conversions work on a wide carrier; callers zero-extend in and truncate out,
  // which is exact for any pointer width up to MAX_PTR_W.
  localparam int MAX_PTR_W = 32;
  typedef logic [MAX_PTR_W-1:0] ptr_max_t;

  function automatic ptr_max_t bin2gray(input ptr_max_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t gray);
    ptr_max_t bin;
    bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Generic N-stage, W-bit flop synchronizer for Gray-coded pointers crossing
// clock domains; synchronous active-high reset clears every stage.
module ptr_sync #(
  parameter int W      = 6,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_q [STAGES];

  // NOTE: every stage is reset, so no stale pointer from before reset can reach
  // the flag logic; the chain stays a plain shift with no bypass path.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/fifo_write_ctrl.sv
// Write-side pointer and flag controller of the dual-clock FIFO: synchronizes the
// read pointer into w_clk and produces write pointers, full/almost_full, level, overflow.
module fifo_write_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEFAULT,
  parameter int AF_LEVEL    = 28,
  parameter int SYNC_STAGES = 2
) (
  input  logic              w_clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   r_ptr_gray,
  output logic [ADDR_W:0]   w_ptr,
  output logic [ADDR_W:0]   w_ptr_gray,
  output logic [ADDR_W-1:0] w_addr,
  output logic              mem_we,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   w_level,
  output logic              overflow
);

  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(AF_LEVEL);

  logic [PTR_W-1:0] r_sync_gray;
  logic [PTR_W-1:0] r_sync_bin;
  logic [PTR_W-1:0] w_ptr_inc;

  ptr_sync #(
    .W      (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_r_ptr_sync (
    .clk (w_clk),
    .rst (rst),
    .d   (r_ptr_gray),
    .q   (r_sync_gray)
  );

  assign r_sync_bin = PTR_W'(gray2bin(MAX_PTR_W'(r_sync_gray)));
  assign w_ptr_inc  = w_ptr + PTR_W'(1);

  // Flags depend only on registers, so wr_en never reaches full combinationally.
  assign w_level     = w_ptr - r_sync_bin;
  assign full        = (w_ptr[ADDR_W] != r_sync_bin[ADDR_W]) &&
                       (w_ptr[ADDR_W-1:0] == r_sync_bin[ADDR_W-1:0]);
  assign almost_full = (w_level >= AF_THRESH);
  assign mem_we      = wr_en & ~full;
  assign w_addr      = w_ptr[ADDR_W-1:0];

  // NOTE: non-blocking assignments let both pointers update from the same old
  // w_ptr at one edge, keeping the Gray output glitch-free toward the read side.
  always_ff @(posedge w_clk) begin
    if (rst) begin
      w_ptr      <= '0;
      w_ptr_gray <= '0;
      overflow   <= 1'b0;
    end else begin
      if (mem_we) begin
        w_ptr      <= w_ptr_inc;
        w_ptr_gray <= PTR_W'(bin2gray(MAX_PTR_W'(w_ptr_inc)));
      end
      if (wr_en && full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Scoreboard bench for fifo_write_ctrl: stimulus pushes model-predicted outputs,
// a negedge monitor pops and compares; directed checks cover the key boundaries.
module tb_fifo_write_ctrl;

  logic       w_clk;
  logic       rst;
  logic       wr_en;
  logic [5:0] r_ptr_gray;
  logic [5:0] w_ptr;
  logic [5:0] w_ptr_gray;
  logic [4:0] w_addr;
  logic       mem_we;
  logic       full;
  logic       almost_full;
  logic [5:0] w_level;
  logic       overflow;

  fifo_write_ctrl #(
    .ADDR_W      (5),
    .AF_LEVEL    (28),
    .SYNC_STAGES (2)
  ) dut (
    .w_clk       (w_clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .r_ptr_gray  (r_ptr_gray),
    .w_ptr       (w_ptr),
    .w_ptr_gray  (w_ptr_gray),
    .w_addr      (w_addr),
    .mem_we      (mem_we),
    .full        (full),
    .almost_full (almost_full),
    .w_level     (w_level),
    .overflow    (overflow)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  typedef struct packed {
    logic [5:0] w_ptr;
    logic [5:0] w_ptr_gray;
    logic [4:0] w_addr;
    logic       mem_we;
    logic       full;
    logic       almost_full;
    logic [5:0] w_level;
    logic       overflow;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model: write count, binary read pointer through a 2-deep delay.
  int m_wp = 0;
  int m_ov = 0;
  int m_s0 = 0;
  int m_s1 = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_level();
    return ((m_wp - m_s1) % 64 + 64) % 64;
  endfunction

  task automatic step(input logic wr, input int rd, input logic rs, input bit push);
    exp_t e;
    int   lvl;
    bit   m_full;
    wr_en      = wr;
    r_ptr_gray = 6'(rd ^ (rd >> 1));
    rst        = rs;
    lvl    = model_level();
    m_full = (lvl == 32);
    if (push) begin
      e.w_ptr       = 6'(m_wp);
      e.w_ptr_gray  = 6'(m_wp ^ (m_wp >> 1));
      e.w_addr      = 5'(m_wp % 32);
      e.mem_we      = wr && !m_full;
      e.full        = m_full;
      e.almost_full = (lvl >= 28);
      e.w_level     = 6'(lvl);
      e.overflow    = (m_ov != 0);
      sb.push_back(e);
    end
    @(posedge w_clk);
    if (rs) begin
      m_wp = 0; m_ov = 0; m_s0 = 0; m_s1 = 0;
    end else begin
      if (wr && m_full) m_ov = 1;
      if (wr && !m_full) m_wp = (m_wp + 1) % 64;
      m_s1 = m_s0;
      m_s0 = rd % 64;
    end
    #1;
  endtask

  always @(negedge w_clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_w_ptr",       int'(w_ptr),       int'(e.w_ptr));
      check("sb_w_ptr_gray",  int'(w_ptr_gray),  int'(e.w_ptr_gray));
      check("sb_w_addr",      int'(w_addr),      int'(e.w_addr));
      check("sb_mem_we",      int'(mem_we),      int'(e.mem_we));
      check("sb_full",        int'(full),        int'(e.full));
      check("sb_almost_full", int'(almost_full), int'(e.almost_full));
      check("sb_w_level",     int'(w_level),     int'(e.w_level));
      check("sb_overflow",    int'(overflow),    int'(e.overflow));
    end
  end

  initial begin
    int         rd;
    logic [5:0] prev_gray;
    bit         seen_zero;
    bit         seen_full;

    rst = 1'b1; wr_en = 1'b0; r_ptr_gray = '0;
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);

    // Reset state.
    step(1'b0, 0, 1'b0, 1'b1);
    check("rst_w_ptr",    int'(w_ptr), 0);
    check("rst_level",    int'(w_level), 0);
    check("rst_full",     int'(full), 0);
    check("rst_overflow", int'(overflow), 0);

    // Fill with the reader parked at 0.
    for (int i = 1; i <= 32; i++) begin
      step(1'b1, 0, 1'b0, 1'b1);
      if (i == 27) check("af_before_28", int'(almost_full), 0);
      if (i == 28) begin
        check("af_at_28",    int'(almost_full), 1);
        check("level_at_28", int'(w_level), 28);
      end
    end
    check("fill_full",   int'(full), 1);
    check("fill_w_ptr",  int'(w_ptr), 6'b100000);
    check("fill_gray",   int'(w_ptr_gray), 6'b110000);
    check("fill_w_addr", int'(w_addr), 0);
    check("fill_ov",     int'(overflow), 0);

    // Writes while full.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 0, 1'b0, 1'b1);
      check("ovf_set",    int'(overflow), 1);
      check("ovf_w_ptr",  int'(w_ptr), 32);
    end
    step(1'b0, 0, 1'b0, 1'b1);
    check("ovf_sticky", int'(overflow), 1);

    // Reader frees one entry: full clears after exactly two edges.
    step(1'b0, 1, 1'b0, 1'b1);
    check("lat_full_edge1", int'(full), 1);
    step(1'b0, 1, 1'b0, 1'b1);
    check("lat_full_edge2",  int'(full), 0);
    check("lat_level_edge2", int'(w_level), 31);

    // Bring the reader up to 4 behind, then stream with the reader trailing.
    step(1'b0, 28, 1'b0, 1'b1);
    step(1'b0, 28, 1'b0, 1'b1);
    check("trail_level", int'(w_level), 4);
    seen_zero = 1'b0;
    seen_full = 1'b0;
    prev_gray = w_ptr_gray;
    for (int i = 0; i < 64; i++) begin
      rd = (m_wp - 4 + 64) % 64;
      step(1'b1, rd, 1'b0, 1'b1);
      check("gray_one_bit", $countones(w_ptr_gray ^ prev_gray), 1);
      prev_gray = w_ptr_gray;
      if (w_ptr == 6'd0) seen_zero = 1'b1;
      if (full) seen_full = 1'b1;
    end
    check("wrap_seen_zero", int'(seen_zero), 1);
    check("wrap_never_full", int'(seen_full), 0);
    check("wrap_w_ptr", int'(w_ptr), 32);

    // Advance to w_ptr = 20, then reset with a concurrent write.
    for (int i = 0; i < 52; i++) begin
      rd = (m_wp - 4 + 64) % 64;
      step(1'b1, rd, 1'b0, 1'b1);
    end
    check("pre_rst_w_ptr", int'(w_ptr), 20);
    check("pre_rst_ov",    int'(overflow), 1);
    step(1'b1, 0, 1'b1, 1'b1);
    check("mid_rst_w_ptr", int'(w_ptr), 0);
    check("mid_rst_gray",  int'(w_ptr_gray), 0);
    check("mid_rst_addr",  int'(w_addr), 0);
    check("mid_rst_level", int'(w_level), 0);
    check("mid_rst_full",  int'(full), 0);
    check("mid_rst_af",    int'(almost_full), 0);
    check("mid_rst_ov",    int'(overflow), 0);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b1, 0, 1'b0, 1'b1);
    check("post_rst_write", int'(w_ptr), 1);

    @(negedge w_clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_write_ctrl.md
Name: fifo_write_ctrl

Overview:
Write-side pointer and flag controller for the dual-clock FIFO. It is the counterpart of the read-side controller and runs entirely in the write clock domain. It synchronizes the read pointer (Gray coded) into w_clk, maintains the binary and Gray write pointers, drives the memory write enable and address, and generates full, almost_full, fill level and a sticky overflow error.

Parameters:
ADDR_W, 5, memory address width; depth = 2**ADDR_W (32); pointers are ADDR_W+1 bits (6).
AF_LEVEL, 28, almost_full asserts when the write-side fill level is >= AF_LEVEL; legal range 1..2**ADDR_W.
SYNC_STAGES, 2, number of flops in the read-pointer synchronizer; must be >= 2.

Ports:
w_clk  input  1  write-domain clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset, sampled on rising w_clk.
wr_en  input  1  write request from the producer.
r_ptr_gray  input  ADDR_W+1  read pointer, Gray coded, registered in the read domain (asynchronous to w_clk).
w_ptr  output  ADDR_W+1  binary write pointer (register).
w_ptr_gray  output  ADDR_W+1  Gray-coded write pointer (register), sent to the read domain.
w_addr  output  ADDR_W  memory write address = w_ptr[ADDR_W-1:0].
mem_we  output  1  memory write strobe = wr_en & ~full (combinational).
full  output  1  FIFO full as seen from the write domain.
almost_full  output  1  fill level >= AF_LEVEL.
w_level  output  ADDR_W+1  write-side fill level, 0..2**ADDR_W.
overflow  output  1  sticky error: a write was attempted while full.

Behaviour:
- Reset (rst=1 at an edge): w_ptr=0, w_ptr_gray=0, all synchronizer stages=0, overflow=0. This gives full=0, almost_full=0, w_level=0, w_addr=0. Reset overrides wr_en at the same edge. Reset mid-operation discards the in-flight pointer state, and the same reset must be applied to the read side.
- Synchronizer: SYNC_STAGES-deep flop chain on r_ptr_gray. It has no other logic and no reset bypass. r_sync_bin = gray2bin(last stage).
- Latency: a change on r_ptr_gray affects full, w_level and almost_full after exactly SYNC_STAGES rising edges of w_clk.
- Accepted write: mem_we=1 in cycle k. At edge k, w_ptr <= w_ptr+1 (mod 2**(ADDR_W+1)) and w_ptr_gray <= bin2gray(w_ptr+1). Both pointers are updated in the same edge, so the Gray output never glitches.
- Derived signals, all combinational from registers only:
  - w_level = (w_ptr - r_sync_bin) mod 2**(ADDR_W+1).
  - full = (w_ptr[ADDR_W] != r_sync_bin[ADDR_W]) && (w_ptr[ADDR_W-1:0] == r_sync_bin[ADDR_W-1:0]), which is equivalent to w_level == 2**ADDR_W.
  - almost_full = (w_level >= AF_LEVEL).
- Write while full: mem_we=0 and pointers hold. At that edge overflow <= 1, and it stays 1 until rst.
- Pessimism: after the reader frees entries, full stays high until the synchronizer catches up. This is required behaviour. full must never deassert early.
- Wrap-around: pointers roll from all-ones to 0. The extra MSB distinguishes full from empty. w_level arithmetic is modulo 2**(ADDR_W+1).
- Simultaneous events: a write accepted in the same cycle the synchronized read pointer advances is legal. Next-cycle w_level = old level + 1 - read advance.
- No write-to-full combinational path from wr_en to full.

Decomposition:
- Shared package fifo_pkg holds:
  - PTR_W = ADDR_W+1 constant default;
  - functions bin2gray and gray2bin (parameterized width), which are reused by the read side.
- One sub-module, ptr_sync: a generic N-stage, width-W flop synchronizer with synchronous reset, also instantiated on the read side for w_ptr_gray.
- The remainder (pointer regs, flags, overflow) stays flat in fifo_write_ctrl.

Test Plan:
- Reset release with r_ptr_gray=0, wr_en=0 -> w_ptr=0, w_ptr_gray=0, full=0, almost_full=0, w_level=0, overflow=0.
- Hold r_ptr_gray=0 and assert wr_en for 32 cycles:
  - -> mem_we=1 each cycle; after edge 28, almost_full=1 and w_level=28;
  - -> after edge 32, full=1, w_ptr=6'b100000, w_ptr_gray=6'b110000, w_addr=0.
- With full=1, assert wr_en for 3 cycles -> mem_we=0, w_ptr stays 32, overflow=1 from the first such edge and remains 1 after wr_en drops.
- While full, change r_ptr_gray to 6'b000001 (read ptr 1):
  - -> full stays 1 for 1 edge;
  - -> full=0 and w_level=31 after exactly the 2nd w_clk edge.
- Run 64 writes, with r_ptr_gray following the write pointer 4 entries behind -> w_ptr wraps to 0, w_ptr_gray sequence changes one bit per step, full never asserts.
- Assert rst for one cycle with w_ptr=20 and overflow=1 -> next cycle all outputs are at reset values, and a concurrent wr_en is ignored.
